multdiv_seq: RTL and testbench
==============================

// Module: multdiv_seq
// PURPOSE
//  Multi-cycle signed 32-bit multiply/divide unit in the ALU execute stage.
//  Each iteration drives one 32-bit add/subtract step: operand A, operand B and carry-in (cin=1 means subtract).
//  It consumes the sum and carry-out of that step and registers the partial product or remainder.
//  One operation is in flight at a time. Completion is flagged by a one-cycle ready pulse.
// PARAMETERS
//  WIDTH   32  operand/result width; only 32 is supported (fixed by the adder datapath)
//  NITER   32  iterations per operation (= WIDTH)
// PORTS
//  clock            in   1   single clock, rising edge
//  reset_n          in   1   asynchronous, active-low reset
//  data_operandA    in   32  multiplicand / dividend, two's complement
//  data_operandB    in   32  multiplier / divisor, two's complement
//  ctrl_MULT        in   1   start-multiply pulse, sampled only in IDLE
//  ctrl_DIV         in   1   start-divide pulse, sampled only in IDLE
//  data_result      out  32  low 32 bits of product, or quotient
//  data_exception   out  1   mult overflow / div-by-zero / div overflow
//  data_resultRDY   out  1   one-cycle pulse: result and exception valid
// BEHAVIOUR
//  Reset (async, reset_n=0): state=IDLE, counter=0, data_result=0, data_exception=0, data_resultRDY=0.
//  Reset mid-operation aborts the operation; no RDY pulse is produced.
//  FSM: IDLE -> RUN -> DONE -> IDLE.
//   - IDLE: at an edge with ctrl_MULT|ctrl_DIV, latch both operands and the op, clear counter, go to RUN.
//   - RUN: one iteration per cycle; after iteration 32 (counter==31), go to DONE.
//   - DONE: register result/exception, pulse data_resultRDY=1 for exactly one cycle, return to IDLE.
//  Latency: start sampled at edge E0; RDY is high in the cycle following edge E33.
//  A new start is accepted in that same RDY cycle.
//  ctrl_* while in RUN/DONE: ignored, not queued.
//  ctrl_MULT and ctrl_DIV asserted together: executed as MULT.
//  Multiply: radix-2 Booth over a 65-bit {P_hi,P_lo,q_-1} register.
//   - Per cycle: bit pair 01 -> add B, 10 -> subtract B (cin=1), 00/11 -> no add.
//   - Then arithmetic right shift by 1.
//   - data_result = P[31:0].
//   - data_exception = 1 iff P[63:32] is not all copies of P[31].
//  Divide: restoring division on magnitudes.
//   - Per cycle: shift {R,Q} left by 1, then R - |B| via the adder.
//   - If carry-out=1: keep the difference and set Q[0]=1; else restore R.
//   - Quotient sign = A[31]^B[31], truncated toward zero; remainder is discarded.
//   - Operand magnitudes and the final quotient negation use a second adder instance (0 - x); this adds no cycles.
//   - B==0: result=0, exception=1.
//   - A=0x80000000 with B=0xFFFFFFFF: result=0x80000000, exception=1.
//  data_result/data_exception hold their values after RDY until the next DONE.
//  They do not change during RUN.
// CONFIGURATION
//  MULTDIV_ZERO_FAST_EN defined:
//   - From IDLE, go directly to DONE (RDY after edge E1) when:
//     MULT with A==0 or B==0 -> result=0, exc=0;
//     DIV with B==0 -> result=0, exc=1;
//     DIV with A==0 -> result=0, exc=0.
//  MULTDIV_ZERO_FAST_EN undefined: all operations take the fixed 33-cycle latency.
// STRUCTURE
//  Shared package multdiv_pkg:
//   - state enum {IDLE,RUN,DONE};
//   - op enum {OP_MULT,OP_DIV};
//   - constants NITER=32 and INT_MIN=32'h80000000.
//  Datapath: the existing 32-bit add/subtract module (two instances: iteration step, negate).
//  One new sub-module is natural: md_iter_counter.
//   - 5-bit counter with clear/enable.
//   - Terminal flag at 31.
//   - Async active-low reset.
// TESTING
//  1. MULT 7 x -3 -> RDY exactly 33 cycles after start; result 0xFFFFFFEB, exc 0.
//  2. MULT 0x00010000 x 0x00010000 -> result 0x00000000, exc 1 (overflow).
//  3. DIV -100 / 7 -> result 0xFFFFFFF2 (-14), exc 0.
//     DIV 100 / -7 -> result -14.
//  4. DIV 5 / 0 -> result 0, exc 1.
//     DIV 0x80000000 / -1 -> result 0x80000000, exc 1.
//  5. Start MULT, then pulse ctrl_DIV at cycle 5 -> ignored; only the MULT RDY appears.
//     Start a new op in the RDY cycle -> accepted.
//  6. reset_n low at cycle 10 of a DIV -> outputs 0 immediately; no RDY.
//     Next MULT 3 x 4 -> result 12.
//     With MULTDIV_ZERO_FAST_EN: MULT 0 x 9 -> RDY after 1 cycle, result 0.

Source files
------------

// File: rtl/multdiv_pkg.sv
// Shared types and constants for the sequential multiply/divide unit.
package multdiv_pkg;

  localparam int          NITER   = 32;
  localparam logic [31:0] INT_MIN = 32'h8000_0000;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  typedef enum logic {
    OP_MULT = 1'b0,
    OP_DIV  = 1'b1
  } op_t;

endpackage

// File: rtl/multdiv_seq_addsub.sv
// 32-bit add/subtract datapath block: sum = a + b (cin=0) or a - b (cin=1),
// with the carry out of bit 31 exposed.
module addsub32 (
  input  logic [31:0] i_a,
  input  logic [31:0] i_b,
  input  logic        i_cin,
  output logic [31:0] o_sum,
  output logic        o_cout
);

  logic [31:0] w_b_eff;
  logic [32:0] w_full;

  assign w_b_eff = i_cin ? ~i_b : i_b;
  assign w_full  = {1'b0, i_a} + {1'b0, w_b_eff} + {32'd0, i_cin};
  assign o_sum   = w_full[31:0];
  assign o_cout  = w_full[32];

endmodule

// File: rtl/multdiv_seq_md_iter_counter.sv
// Iteration counter for the multiply/divide loop: 5-bit, synchronous clear
// and enable, terminal flag on the last iteration.
module md_iter_counter
  import multdiv_pkg::*;
(
  input  logic clk,
  input  logic rst_n,
  input  logic i_clr,
  input  logic i_en,
  output logic o_term
);

  logic [4:0] r_cnt;

  // Count iterations while enabled; clear has priority.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= '0;
    end else if (i_clr) begin
      r_cnt <= '0;
    end else if (i_en) begin
      r_cnt <= r_cnt + 5'd1;
    end
  end

  assign o_term = (r_cnt == 5'(NITER - 1));

endmodule

// File: rtl/multdiv_seq.sv
// Sequential signed 32-bit multiply (radix-2 Booth) / divide (restoring on
// magnitudes). One operation in flight; result flagged by a one-cycle
// data_resultRDY pulse 33 cycles after the start edge.
// Optional feature macro: MULTDIV_ZERO_FAST_EN -- zero operands skip the
// iteration loop and complete one cycle after the start edge.
module multdiv_seq
  import multdiv_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic [WIDTH-1:0] data_operandA,
  input  logic [WIDTH-1:0] data_operandB,
  input  logic             ctrl_MULT,
  input  logic             ctrl_DIV,
  output logic [WIDTH-1:0] data_result,
  output logic             data_exception,
  output logic             data_resultRDY
);

  state_t      r_state;
  op_t         r_op;
  logic [31:0] r_hi;     // Booth P_hi, or division remainder
  logic [31:0] r_lo;     // Booth P_lo, or division quotient
  logic        r_qm1;    // Booth q(-1)
  logic [31:0] r_b;      // raw operand B
  logic        r_neg;    // quotient sign
  logic [31:0] r_result;
  logic        r_exc;
  logic        r_rdy;

  logic        w_start;
  logic        w_fast;
  logic        w_term;

  logic [31:0] w_neg_in;
  logic [31:0] w_neg_sum;
  logic        w_unused_neg_cout;
  logic [31:0] w_abs_a;
  logic [31:0] w_abs_b;
  logic [31:0] w_quot;

  logic [31:0] w_div_shift;
  logic [31:0] w_step_a;
  logic [31:0] w_step_b;
  logic        w_step_cin;
  logic [31:0] w_step_beff;
  logic [31:0] w_step_sum;
  logic        w_step_cout;
  logic        w_sign33;

  logic [31:0] w_res;
  logic        w_exc;

  assign w_start = (r_state == IDLE) && (ctrl_MULT || ctrl_DIV);

`ifdef MULTDIV_ZERO_FAST_EN
  // Any zero operand has a trivially known result for both operations.
  assign w_fast = w_start && ((data_operandA == '0) || (data_operandB == '0));
`else
  assign w_fast = 1'b0;
`endif

  md_iter_counter u_cnt (
    .clk    (clock),
    .rst_n  (reset_n),
    .i_clr  (w_start),
    .i_en   (r_state == RUN),
    .o_term (w_term)
  );

  // Negate adder is time-shared: |A| at start, |B| during the loop,
  // quotient sign fix-up in DONE.
  always_comb begin
    w_neg_in = r_lo;
    case (r_state)
      IDLE:    w_neg_in = data_operandA;
      RUN:     w_neg_in = r_b;
      default: w_neg_in = r_lo;
    endcase
  end

  addsub32 u_neg (
    .i_a    (32'd0),
    .i_b    (w_neg_in),
    .i_cin  (1'b1),
    .o_sum  (w_neg_sum),
    .o_cout (w_unused_neg_cout)
  );

  assign w_abs_a = data_operandA[31] ? w_neg_sum : data_operandA;
  assign w_abs_b = r_b[31] ? w_neg_sum : r_b;
  assign w_quot  = r_neg ? w_neg_sum : r_lo;

  assign w_div_shift = {r_hi[30:0], r_lo[31]};

  // Step adder operands: trial subtract for divide, Booth add/sub for multiply.
  always_comb begin
    w_step_a   = r_hi;
    w_step_b   = '0;
    w_step_cin = 1'b0;
    if (r_op == OP_DIV) begin
      w_step_a   = w_div_shift;
      w_step_b   = w_abs_b;
      w_step_cin = 1'b1;
    end else begin
      case ({r_lo[0], r_qm1})
        2'b01: w_step_b = r_b;
        2'b10: begin
          w_step_b   = r_b;
          w_step_cin = 1'b1;
        end
        default: ;
      endcase
    end
  end

  addsub32 u_step (
    .i_a    (w_step_a),
    .i_b    (w_step_b),
    .i_cin  (w_step_cin),
    .o_sum  (w_step_sum),
    .o_cout (w_step_cout)
  );

  // True bit 32 of the signed sum, so the Booth shift stays exact even when
  // the 32-bit add overflows (e.g. subtracting INT_MIN).
  assign w_step_beff = w_step_cin ? ~w_step_b : w_step_b;
  assign w_sign33    = w_step_a[31] ^ w_step_beff[31] ^ w_step_cout;

  // Final result and exception from the iteration registers.
  always_comb begin
    w_res = r_lo;
    w_exc = (r_hi != {32{r_lo[31]}});
    if (r_op == OP_DIV) begin
      if (r_b == '0) begin
        w_res = '0;
        w_exc = 1'b1;
      end else begin
        w_res = w_quot;
        w_exc = !r_neg && (r_lo == INT_MIN);
      end
    end
  end

  // Control FSM and iteration datapath.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_state  <= IDLE;
      r_op     <= OP_MULT;
      r_hi     <= '0;
      r_lo     <= '0;
      r_qm1    <= 1'b0;
      r_b      <= '0;
      r_neg    <= 1'b0;
      r_result <= '0;
      r_exc    <= 1'b0;
      r_rdy    <= 1'b0;
    end else begin
      r_rdy <= 1'b0;
      case (r_state)
        IDLE: begin
          if (w_start) begin
            r_op    <= ctrl_MULT ? OP_MULT : OP_DIV;
            r_b     <= data_operandB;
            r_neg   <= data_operandA[31] ^ data_operandB[31];
            r_hi    <= '0;
            r_qm1   <= 1'b0;
            r_lo    <= w_fast ? 32'd0 : (ctrl_MULT ? data_operandA : w_abs_a);
            r_state <= w_fast ? DONE : RUN;
          end
        end
        RUN: begin
          if (r_op == OP_DIV) begin
            if (w_step_cout) begin
              r_hi <= w_step_sum;
              r_lo <= {r_lo[30:0], 1'b1};
            end else begin
              r_hi <= w_div_shift;
              r_lo <= {r_lo[30:0], 1'b0};
            end
          end else begin
            r_hi  <= {w_sign33, w_step_sum[31:1]};
            r_lo  <= {w_step_sum[0], r_lo[31:1]};
            r_qm1 <= r_lo[0];
          end
          if (w_term) begin
            r_state <= DONE;
          end
        end
        DONE: begin
          r_result <= w_res;
          r_exc    <= w_exc;
          r_rdy    <= 1'b1;
          r_state  <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign data_result    = r_result;
  assign data_exception = r_exc;
  assign data_resultRDY = r_rdy;

endmodule

// File: tb/tb_multdiv_seq.sv
// Directed self-checking bench for multdiv_seq.
module tb_multdiv_seq;

  logic        clock = 1'b0;
  logic        reset_n;
  logic [31:0] data_operandA;
  logic [31:0] data_operandB;
  logic        ctrl_MULT;
  logic        ctrl_DIV;
  logic [31:0] data_result;
  logic        data_exception;
  logic        data_resultRDY;

  int checks = 0;
  int errors = 0;

`ifdef MULTDIV_ZERO_FAST_EN
  localparam int ZERO_LAT = 1;
`else
  localparam int ZERO_LAT = 33;
`endif

  multdiv_seq dut (
    .clock          (clock),
    .reset_n        (reset_n),
    .data_operandA  (data_operandA),
    .data_operandB  (data_operandB),
    .ctrl_MULT      (ctrl_MULT),
    .ctrl_DIV       (ctrl_DIV),
    .data_result    (data_result),
    .data_exception (data_exception),
    .data_resultRDY (data_resultRDY)
  );

  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, got, exp);
    end
  endtask

  // Called just after a rising edge; start is sampled at the next edge (E0).
  task automatic go(input logic m, input logic d, input logic [31:0] a, input logic [31:0] b);
    ctrl_MULT     = m;
    ctrl_DIV      = d;
    data_operandA = a;
    data_operandB = b;
    @(posedge clock); #1;
    ctrl_MULT = 1'b0;
    ctrl_DIV  = 1'b0;
  endtask

  // Cycles until RDY is seen, bounded at 40.
  task automatic wait_rdy(output int lat);
    lat = 0;
    while (data_resultRDY !== 1'b1 && lat < 40) begin
      @(posedge clock); #1;
      lat++;
    end
  endtask

  task automatic run_op(input string tag, input logic m, input logic d,
                        input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] exp_r, input logic exp_e, input int exp_lat);
    int lat;
    go(m, d, a, b);
    wait_rdy(lat);
    chk({tag, " latency"}, lat, exp_lat);
    chk({tag, " result"}, data_result, exp_r);
    chk({tag, " exc"}, {31'd0, data_exception}, {31'd0, exp_e});
    @(posedge clock); #1;
    chk({tag, " rdy pulse"}, {31'd0, data_resultRDY}, 32'd0);
  endtask

  initial begin
    int lat;
    int seen;
    reset_n       = 1'b0;
    ctrl_MULT     = 1'b0;
    ctrl_DIV      = 1'b0;
    data_operandA = '0;
    data_operandB = '0;
    repeat (2) @(posedge clock);
    #1;
    chk("reset result", data_result, 32'd0);
    chk("reset exc", {31'd0, data_exception}, 32'd0);
    chk("reset rdy", {31'd0, data_resultRDY}, 32'd0);
    reset_n = 1'b1;
    @(posedge clock); #1;

    // Multiply
    run_op("mul 7x-3",     1, 0, 32'd7,          32'hFFFF_FFFD, 32'hFFFF_FFEB, 1'b0, 33);
    run_op("mul 2^16^2",   1, 0, 32'h0001_0000,  32'h0001_0000, 32'h0000_0000, 1'b1, 33);
    run_op("mul min*min",  1, 0, 32'h8000_0000,  32'h8000_0000, 32'h0000_0000, 1'b1, 33);
    run_op("mul -1*-1",    1, 0, 32'hFFFF_FFFF,  32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 33);
    run_op("mul max*2",    1, 0, 32'h7FFF_FFFF,  32'd2,         32'hFFFF_FFFE, 1'b1, 33);
    run_op("mul both",     1, 1, 32'd6,          32'd7,         32'd42,        1'b0, 33);

    // Divide
    run_op("div -100/7",   0, 1, 32'hFFFF_FF9C,  32'd7,         32'hFFFF_FFF2, 1'b0, 33);
    run_op("div 100/-7",   0, 1, 32'd100,        32'hFFFF_FFF9, 32'hFFFF_FFF2, 1'b0, 33);
    run_op("div -7/2",     0, 1, 32'hFFFF_FFF9,  32'd2,         32'hFFFF_FFFD, 1'b0, 33);
    run_op("div 5/0",      0, 1, 32'd5,          32'd0,         32'd0,         1'b1, ZERO_LAT);
    run_op("div min/-1",   0, 1, 32'h8000_0000,  32'hFFFF_FFFF, 32'h8000_0000, 1'b1, 33);
    run_op("div min/1",    0, 1, 32'h8000_0000,  32'd1,         32'h8000_0000, 1'b0, 33);

    // ctrl_DIV during RUN is ignored; a start in the RDY cycle is accepted
    go(1, 0, 32'd7, 32'd5);
    repeat (4) begin @(posedge clock); #1; end
    ctrl_DIV      = 1'b1;
    data_operandA = 32'd100;
    data_operandB = 32'd7;
    @(posedge clock); #1;
    ctrl_DIV = 1'b0;
    wait_rdy(lat);
    chk("ignore latency", lat + 5, 32'd33);
    chk("ignore result", data_result, 32'd35);
    go(1, 0, 32'hFFFF_FFFE, 32'd6);
    wait_rdy(lat);
    chk("back2back latency", lat, 32'd33);
    chk("back2back result", data_result, 32'hFFFF_FFF4);

    // Reset in the middle of a divide
    @(posedge clock); #1;
    go(0, 1, 32'd1000, 32'd3);
    repeat (9) begin @(posedge clock); #1; end
    reset_n = 1'b0;
    #1;
    chk("midreset result", data_result, 32'd0);
    chk("midreset exc", {31'd0, data_exception}, 32'd0);
    chk("midreset rdy", {31'd0, data_resultRDY}, 32'd0);
    #3;
    reset_n = 1'b1;
    seen = 0;
    repeat (40) begin
      @(posedge clock); #1;
      if (data_resultRDY === 1'b1) seen++;
    end
    chk("midreset no rdy", seen, 32'd0);
    run_op("mul 3x4",      1, 0, 32'd3,          32'd4,         32'd12,        1'b0, 33);

    // Zero operands
    run_op("mul 0x9",      1, 0, 32'd0,          32'd9,         32'd0,         1'b0, ZERO_LAT);
    run_op("mul 9x0",      1, 0, 32'd9,          32'd0,         32'd0,         1'b0, ZERO_LAT);
    run_op("div 0/9",      0, 1, 32'd0,          32'd9,         32'd0,         1'b0, ZERO_LAT);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
